// File: rtl/serial_pattern_recognizer.sv
`default_nettype none
// ============================================================================
// serial_pattern_recognizer - masked serial pattern matcher with overlap mode.
// Optional saturating match counter is built when SPR_MATCH_COUNT_EN is defined.
// Revision: 1.0
// ============================================================================
module serial_pattern_recognizer #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             linea,
  input  logic             linea_valid,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cfg_overlap,
  output logic             u,
  output logic             busy,
  output logic [PAT_W-1:0] window,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  state_t           state;
  logic [FW-1:0]    fill_cnt;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic             overlap;

  logic [PAT_W-1:0] nxt;
  logic             accept;
  logic             full;
  logic             hit;

  // A bit is evaluated only once the window holds PAT_W fresh bits.
  always_comb begin
    nxt    = {window[PAT_W-2:0], linea};
    accept = enable && !cfg_load && linea_valid && (state != IDLE);
    full   = (state == HUNT) || (fill_cnt == FW'(PAT_W - 1));
    hit    = accept && full && (((nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      window   <= '0;
      fill_cnt <= '0;
      u        <= 1'b0;
      busy     <= 1'b0;
      pattern  <= '0;
      mask     <= '1;
      overlap  <= 1'b1;
    end else if (cfg_load) begin
      pattern  <= cfg_pattern;
      mask     <= cfg_mask;
      overlap  <= cfg_overlap;
      state    <= IDLE;
      window   <= '0;
      fill_cnt <= '0;
      u        <= 1'b0;
      busy     <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      window   <= '0;
      fill_cnt <= '0;
      u        <= 1'b0;
      busy     <= 1'b0;
    end else begin
      u <= hit;
      case (state)
        IDLE: begin
          state <= FILL;
          busy  <= 1'b1;
        end
        FILL: begin
          if (linea_valid) begin
            window <= nxt;
            if (full) begin
              fill_cnt <= '0;
              state    <= (hit && !overlap) ? FILL : HUNT;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        HUNT: begin
          if (linea_valid) begin
            window <= nxt;
            // Non-overlapping mode restarts the fill after each match.
            if (hit && !overlap) begin
              state    <= FILL;
              fill_cnt <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPR_MATCH_COUNT_EN
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || cfg_load) begin
      count <= '0;
    end else if (hit && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign match_count = count;
`else
  assign match_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_recognizer.sv
`default_nettype none
// Directed self-checking bench for serial_pattern_recognizer (PAT_W=4, CNT_W=8).
module tb_serial_pattern_recognizer;

  logic       clock = 1'b0;
  logic       reset;
  logic       linea;
  logic       linea_valid;
  logic       enable;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cfg_overlap;
  logic       u;
  logic       busy;
  logic [3:0] window;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SPR_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  serial_pattern_recognizer #(.PAT_W(4), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .linea       (linea),
    .linea_valid (linea_valid),
    .enable      (enable),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .cfg_overlap (cfg_overlap),
    .u           (u),
    .busy        (busy),
    .window      (window),
    .match_count (match_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic exp_u, input string tag);
    linea       = b;
    linea_valid = 1'b1;
    step();
    linea_valid = 1'b0;
    check(tag, 32'(u), 32'(exp_u));
  endtask

  task automatic configure(input logic [3:0] p, input logic [3:0] m, input logic ov);
    cfg_pattern = p;
    cfg_mask    = m;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    enable      = 1'b1;
    step();
    cfg_load = 1'b0;
    step();
  endtask

  initial begin
    logic [6:0] stream;
    stream = 7'b1011011;

    // 1: reset with random inputs
    reset       = 1'b1;
    linea       = 1'($urandom);
    linea_valid = 1'($urandom);
    enable      = 1'($urandom);
    cfg_load    = 1'($urandom);
    cfg_pattern = 4'($urandom);
    cfg_mask    = 4'($urandom);
    cfg_overlap = 1'($urandom);
    step();
    linea       = 1'($urandom);
    linea_valid = 1'($urandom);
    step();
    check("rst_u", 32'(u), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_window", 32'(window), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    reset = 1'b0; linea_valid = 1'b0; enable = 1'b0; cfg_load = 1'b0;
    step();

    // 2: overlapping matches of 1011 in 1011011
    configure(4'b1011, 4'b1111, 1'b1);
    check("ov_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++)
      send_bit(stream[6-i], (i == 3) || (i == 6), "ov_u");
    step();
    check("ov_u_after", 32'(u), 32'd0);
    check("ov_count", 32'(match_count), exp_cnt(2));

    // 3: same stream, non-overlapping
    configure(4'b1011, 4'b1111, 1'b0);
    for (int i = 0; i < 7; i++)
      send_bit(stream[6-i], (i == 3), "nov_u");
    check("nov_count", 32'(match_count), exp_cnt(1));
    check("nov_busy", 32'(busy), 32'd1);

    // 4: middle bits don't care
    configure(4'b1001, 4'b1001, 1'b1);
    for (int i = 0; i < 4; i++)
      send_bit(1'b1, (i == 3), "mask_u");
    check("mask_window", 32'(window), 32'hF);

    // 5: gaps of linea_valid=0 between bits
    configure(4'b1011, 4'b1111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_bit(stream[6-i], (i == 3), "gap_u");
      for (int g = 0; g < 3; g++) begin
        step();
        check("gap_idle_u", 32'(u), 32'd0);
      end
    end
    check("gap_window", 32'(window), 32'hB);
    check("gap_count", 32'(match_count), exp_cnt(1));

    // enable falls with the completing bit: bit dropped, no pulse
    configure(4'b1011, 4'b1111, 1'b1);
    send_bit(1'b1, 1'b0, "en_u");
    send_bit(1'b0, 1'b0, "en_u");
    send_bit(1'b1, 1'b0, "en_u");
    enable = 1'b0;
    send_bit(1'b1, 1'b0, "en_drop_u");
    check("en_drop_busy", 32'(busy), 32'd0);
    check("en_drop_window", 32'(window), 32'd0);
    check("en_drop_count", 32'(match_count), exp_cnt(0));

    // reset on the completing bit: no pulse, reset values back
    configure(4'b1011, 4'b1111, 1'b1);
    send_bit(1'b1, 1'b0, "rs_u");
    send_bit(1'b0, 1'b0, "rs_u");
    send_bit(1'b1, 1'b0, "rs_u");
    reset = 1'b1;
    send_bit(1'b1, 1'b0, "rs_drop_u");
    reset = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_window", 32'(window), 32'd0);

    // 6: mask=0 saturates the counter, then cfg_load clears it
    configure(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++)
      send_bit(1'($urandom_range(0, 1)), (i >= 3), "sat_u");
    step();
    check("sat_count", 32'(match_count), exp_cnt(255));
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    check("clr_count", 32'(match_count), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_window", 32'(window), 32'd0);
    check("clr_u", 32'(u), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
